// File: rtl/bcd_counter_n_if.sv
// Control/status bundle for the multi-digit BCD counter.
// The master drives count controls and load data; the slave returns count and flags.
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  ld;
  logic [4*DIGITS-1:0]   ld_val;
  logic [4*DIGITS-1:0]   cnt;
  logic                  tc;
  logic                  wrap;
  logic                  ld_err;

  modport master (
    output en, up, ld, ld_val,
    input  cnt, tc, wrap, ld_err
  );

  modport slave (
    input  en, up, ld, ld_val,
    output cnt, tc, wrap, ld_err
  );
endinterface

// File: rtl/bcd_counter_n.sv
// Cascaded DIGITS-digit BCD up/down counter with parallel load,
// wrap or saturate at the range ends, and terminal-count/wrap/load-error flags.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  bcd_counter_n_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_cnt;
  logic         r_wrap;
  logic         r_ld_err;
  logic         r_in_rst;

  logic [W-1:0] w_cnt_nxt;
  logic         w_at_end;
  logic         w_ld_ok;

  // Ripple the step condition up through the digits; w_at_end ends up true
  // only when every digit sits at its terminal value for the current direction.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_at_end  = 1'b1;
    w_ld_ok   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_at_end) begin
        if (bus.up) begin
          w_cnt_nxt[4*k +: 4] = (r_cnt[4*k +: 4] == 4'd9) ? 4'd0 : r_cnt[4*k +: 4] + 4'd1;
        end else begin
          w_cnt_nxt[4*k +: 4] = (r_cnt[4*k +: 4] == 4'd0) ? 4'd9 : r_cnt[4*k +: 4] - 4'd1;
        end
      end
      w_at_end = w_at_end & (bus.up ? (r_cnt[4*k +: 4] == 4'd9) : (r_cnt[4*k +: 4] == 4'd0));
      if (bus.ld_val[4*k +: 4] > 4'd9) begin
        w_ld_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_in_rst <= ~rst;
    if (!rst) begin
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
      if (bus.ld) begin
        if (w_ld_ok) begin
          r_cnt <= bus.ld_val;
        end else begin
          r_ld_err <= 1'b1;
        end
      end else if (bus.en) begin
        if (!w_at_end) begin
          r_cnt <= w_cnt_nxt;
        end else if (!SAT) begin
          r_cnt  <= w_cnt_nxt;
          r_wrap <= 1'b1;
        end
      end
    end
  end

  assign bus.cnt    = r_cnt;
  // Held low through reset so every output reads 0 until the first post-reset edge.
  assign bus.tc     = bus.en & w_at_end & ~r_in_rst;
  assign bus.wrap   = r_wrap;
  assign bus.ld_err = r_ld_err;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench: three counters (4 digits wrap, 4 digits saturate, 1 digit wrap)
// driven in lockstep and compared against an integer-arithmetic reference model.
module tb_bcd_counter_n;
  logic clk;
  logic rst;

  bcd_counter_n_if #(.DIGITS(4)) if0 ();
  bcd_counter_n_if #(.DIGITS(4)) if1 ();
  bcd_counter_n_if #(.DIGITS(1)) if2 ();

  bcd_counter_n #(.DIGITS(4), .SAT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  bcd_counter_n #(.DIGITS(4), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_counter_n #(.DIGITS(1), .SAT(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       tc;
    logic [2:0]       wrap;
    logic [2:0]       lderr;
    logic [2:0][15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  int dg  [3] = '{4, 4, 1};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};
  int mv  [3] = '{0, 0, 0};
  bit mw  [3] = '{1'b0, 1'b0, 1'b0};
  bit me  [3] = '{1'b0, 1'b0, 1'b0};
  bit mir [3] = '{1'b1, 1'b1, 1'b1};

  logic [2:0]  m_tc, m_wrap, m_lderr;
  logic [15:0] m_cnt [3];
  assign m_tc    = {if2.tc, if1.tc, if0.tc};
  assign m_wrap  = {if2.wrap, if1.wrap, if0.wrap};
  assign m_lderr = {if2.ld_err, if1.ld_err, if0.ld_err};
  assign m_cnt[0] = if0.cnt;
  assign m_cnt[1] = if1.cnt;
  assign m_cnt[2] = {12'd0, if2.cnt};

  function automatic int pow10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] b, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int d);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit is_bcd(input logic [15:0] b, input int d);
    bit ok = 1'b1;
    for (int i = 0; i < d; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, advance the model, queue the expectation.
  task automatic cyc(input bit r, input bit en_i, input bit up_i, input bit ld_i,
                     input logic [15:0] lv, input bit push);
    exp_t e;
    logic [15:0] lvk;
    int mx;
    @(negedge clk);
    rst = r;
    if0.en = en_i; if0.up = up_i; if0.ld = ld_i; if0.ld_val = lv;
    if1.en = en_i; if1.up = up_i; if1.ld = ld_i; if1.ld_val = lv;
    if2.en = en_i; if2.up = up_i; if2.ld = ld_i; if2.ld_val = lv[3:0];
    e = '0;
    for (int k = 0; k < 3; k++) begin
      mx  = pow10(dg[k]) - 1;
      lvk = (dg[k] == 1) ? {12'd0, lv[3:0]} : lv;
      e.tc[k] = !mir[k] && en_i && (up_i ? (mv[k] == mx) : (mv[k] == 0));
      if (!r) begin
        mv[k] = 0; mw[k] = 1'b0; me[k] = 1'b0; mir[k] = 1'b1;
      end else begin
        mw[k] = 1'b0; me[k] = 1'b0; mir[k] = 1'b0;
        if (ld_i) begin
          if (is_bcd(lvk, dg[k])) mv[k] = bcd2int(lvk, dg[k]);
          else me[k] = 1'b1;
        end else if (en_i) begin
          if (up_i) begin
            if (mv[k] < mx) mv[k] = mv[k] + 1;
            else if (!sat[k]) begin mv[k] = 0; mw[k] = 1'b1; end
          end else begin
            if (mv[k] > 0) mv[k] = mv[k] - 1;
            else if (!sat[k]) begin mv[k] = mx; mw[k] = 1'b1; end
          end
        end
      end
      e.cnt[k]   = int2bcd(mv[k], dg[k]);
      e.wrap[k]  = mw[k];
      e.lderr[k] = me[k];
    end
    if (push) q.push_back(e);
  endtask

  // Monitor: tc is checked before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int k = 0; k < 3; k++) chk("tc", k, {15'd0, m_tc[k]}, {15'd0, e.tc[k]});
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          chk("cnt", k, m_cnt[k], e.cnt[k]);
          chk("wrap", k, {15'd0, m_wrap[k]}, {15'd0, e.wrap[k]});
          chk("ld_err", k, {15'd0, m_lderr[k]}, {15'd0, e.lderr[k]});
        end
      end
    end
  end

  initial begin
    logic [15:0] lv;
    rst = 1'b0;
    if0.en = 1'b0; if0.up = 1'b0; if0.ld = 1'b0; if0.ld_val = '0;
    if1.en = 1'b0; if1.up = 1'b0; if1.ld = 1'b0; if1.ld_val = '0;
    if2.en = 1'b0; if2.up = 1'b0; if2.ld = 1'b0; if2.ld_val = '0;

    // Reset with load and count requested, then idle hold.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Up through carry into the range end.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h9998, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Down with borrow, then underflow.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Hold at all-9s going up, then at all-0s going down.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Load priority and rejected load.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h12A4, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hF00B, 1'b1);

    // Oscillating direction at the ends, then a load straight after a wrap.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i[0], 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0555, 1'b1);

    // Reset landing on the edge that would carry into 0x1000.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0998, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Randomised traffic, biased toward the range ends.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        default: for (int d = 0; d < 4; d++) lv[4*d +: 4] = 4'($urandom_range(0, 9));
      endcase
      if ($urandom_range(0, 5) == 0) lv[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 7) == 0), lv, 1'b1);
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD counter. It extends the single-digit 0-9 counter to DIGITS cascaded decimal digits, with up/down counting, synchronous parallel load, and wrap or saturate mode. It also provides terminal-count and wrap flags for chaining into further counters or display logic. It sits between control FSMs and seven-segment/display drivers in the PBL projects.

## Interface
- DIGITS, 4: number of BCD digits (1..8); counter range 0 .. 10^DIGITS-1
- SAT, 0: 0 = wrap at range ends, 1 = saturate (hold at end value)
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is synchronous and active-low
- en  input  1  count enable, active high
- up  input  1  direction: 1 = increment, 0 = decrement
- ld  input  1  synchronous load strobe, active high
- ld_val  input  4*DIGITS  BCD load value; digit k at bits [4k+3:4k]; digit 0 = least significant
- cnt  output  4*DIGITS  current BCD count, same packing as ld_val
- tc  output  1  terminal count, combinational
- wrap  output  1  registered one-cycle pulse: the count wrapped
- ld_err  output  1  registered one-cycle pulse: the load was rejected

## Operation
- Priority at each rising clk edge: reset, then load, then count, then hold.
- Reset (rst=0 at the edge):
  - cnt=0, wrap=0, ld_err=0.
  - Overrides ld and en.
- Load (ld=1):
  - If every digit of ld_val is 0..9, cnt takes ld_val.
  - If any digit is 0xA..0xF, cnt holds and ld_err=1 for the next cycle.
  - ld ignores en. No counting occurs in a load cycle.
- Count (ld=0, en=1):
  - Each digit is a mod-10 counter.
  - Digit k steps only when all lower digits are at their terminal value: 9 when up=1, 0 when up=0.
  - Up: a digit at 9 goes to 0 and carries. Down: a digit at 0 goes to 9 and borrows.
- Hold (en=0, ld=0): cnt unchanged. There is no auto-clear at 9; en=0 always holds.
- Range end, up=1 at all-9s, SAT=0: cnt becomes all-0s and wrap=1 next cycle.
- Range end, up=1 at all-9s, SAT=1: cnt holds all-9s and wrap stays 0.
- Range end, up=0 at all-0s, SAT=0: cnt becomes all-9s and wrap=1 next cycle.
- Range end, up=0 at all-0s, SAT=1: cnt holds all-0s and wrap stays 0.
- tc = en & (up ? cnt==all-9s : cnt==all-0s). It does not depend on SAT. Chain it as en for the next counter stage.
- The up input may change on any cycle; it takes effect at the next edge.
- Internal digits never hold values 0xA..0xF. A loaded value is always valid BCD.

## Timing
- cnt: one-cycle latency from en, up, and ld to the updated value.
- tc: combinational, same cycle. No registered path from en.
- wrap and ld_err:
  - Asserted for exactly the one cycle after the causing edge.
  - Cleared at the next edge unless re-caused.
  - Both are cleared by reset.
- Back-to-back events:
  - Wraps on consecutive edges (DIGITS=1, oscillating direction) give consecutive wrap pulses.
  - A valid load in the cycle after a wrap clears wrap normally.
- Reset mid-count: cnt=0 on the edge that samples rst=0, regardless of ld, en, or an in-flight carry.
- All outputs are 0 from the first edge with rst=0 until the first edge after rst returns to 1.

## Test plan
- Reset and hold:
  - Stimulus: DIGITS=4, rst=0 for 2 cycles with ld=1, en=1; release rst; then en=0 for 5 cycles.
  - Required: cnt=0x0000, wrap=0, ld_err=0 throughout.
- Up count with carry and wrap, SAT=0:
  - Stimulus: load 0x9998, then en=1, up=1 for 3 cycles.
  - Required: cnt goes 0x9999 (tc=1 that cycle), then 0x0000 with wrap=1, then 0x0001 with wrap=0.
- Down count with borrow, SAT=0:
  - Stimulus: load 0x1000, then en=1, up=0.
  - Required: 0x0999. Load 0x0000 and decrement: 0x9999 with wrap=1.
- Saturate, SAT=1:
  - Stimulus: at 0x9999 with up=1, en=1 for 3 cycles; then up=0 at 0x0000.
  - Required: cnt stays 0x9999 and wrap stays 0; then cnt stays 0x0000.
- Load priority and error:
  - Stimulus: at cnt=0x0042 with en=1, ld=1, ld_val=0x12A4.
  - Required: cnt stays 0x0042, ld_err=1 for one cycle. Then ld_val=0x1234 gives cnt=0x1234 and ld_err=0.
- Reset mid-operation:
  - Stimulus: counting up from 0x0998, assert rst=0 on the edge where the carry would produce 0x1000.
  - Required: cnt=0x0000 and wrap=0.
